// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALUControl codes, engine state encoding and default
//               width for multicycle_alu (SIGNED_MULDIV_EN uses MULT/DIV).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;
    localparam logic [3:0] ALU_MFHI  = 4'b1010;
    localparam logic [3:0] ALU_MFLO  = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MULT  = 4'b1101;
    localparam logic [3:0] ALU_DIV   = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_engine.sv
// ============================================================================
// Module      : muldiv_engine
// Description : Iterative shift-add multiplier / restoring divider with HI/LO
//               result registers; SIGNED_MULDIV_EN adds signed MULT/DIV.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_acc, r_q, r_m, r_hi, r_lo;
    logic               r_busy, r_done, r_neg_lo, r_neg_hi;

    logic               w_go_mul, w_go_div, w_sgn, w_ge;
    logic [WIDTH-1:0]   w_a_in, w_b_in, w_trial, w_acc_nxt, w_q_nxt, w_hi_fin, w_lo_fin;
    logic [WIDTH:0]     w_sum, w_rsh;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_go_mul = i_start && (i_op == ALU_MULTU);
        w_go_div = i_start && (i_op == ALU_DIVU);
        w_sgn    = 1'b0;
`ifdef SIGNED_MULDIV_EN
        if (i_start && (i_op == ALU_MULT)) begin
            w_go_mul = 1'b1;
            w_sgn    = 1'b1;
        end
        if (i_start && (i_op == ALU_DIV)) begin
            w_go_div = 1'b1;
            w_sgn    = 1'b1;
        end
`endif
        // Signed operands enter the engine as magnitudes
        w_a_in = (w_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
        w_b_in = (w_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
    end

    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
        w_rsh   = {r_acc, r_q[WIDTH-1]};
        w_ge    = (w_rsh >= {1'b0, r_m});
        // Only the low bits matter: when w_ge holds the difference fits in WIDTH
        w_trial = w_rsh[WIDTH-1:0] - r_m;
        if (r_state == S_MUL) begin
            w_acc_nxt = w_sum[WIDTH:1];
            w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
        end else begin
            w_acc_nxt = w_ge ? w_trial : w_rsh[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
        end
        w_prod = {w_acc_nxt, w_q_nxt};
        if (r_state == S_MUL) begin
            {w_hi_fin, w_lo_fin} = r_neg_lo ? -w_prod : w_prod;
        end else begin
            w_hi_fin = r_neg_hi ? -w_acc_nxt : w_acc_nxt;
            w_lo_fin = r_neg_lo ? -w_q_nxt : w_q_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_go_mul || w_go_div) begin
                        r_state  <= w_go_mul ? S_MUL : S_DIV;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_q      <= w_a_in;
                        r_m      <= w_b_in;
                        r_neg_lo <= w_sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_neg_hi <= w_sgn && i_a[WIDTH-1];
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_hi_fin;
                        r_lo    <= w_lo_fin;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

`default_nettype wire

// File: rtl/multicycle_alu.sv
// ============================================================================
// Module      : multicycle_alu
// Description : Execute-stage ALU: combinational op mux plus iterative
//               mul/div engine; SIGNED_MULDIV_EN enables signed MULT/DIV.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    input  logic             Start,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    logic [WIDTH-1:0] w_hi, w_lo;

    muldiv_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .i_start (Start),
        .i_op    (ALUControl),
        .i_a     (A),
        .i_b     (B),
        .o_busy  (Busy),
        .o_done  (Done),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    // Mul/div launch codes and unused codes all read back as zero
    always_comb begin
        ALUOut = '0;
        case (ALUControl)
            ALU_AND:  ALUOut = A & B;
            ALU_OR:   ALUOut = A | B;
            ALU_ADD:  ALUOut = A + B;
            ALU_XOR:  ALUOut = A ^ B;
            ALU_SLL:  ALUOut = B << A[4:0];
            ALU_SRL:  ALUOut = B >> A[4:0];
            ALU_SUB:  ALUOut = A - B;
            ALU_SLT:  ALUOut = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_MFHI: ALUOut = w_hi;
            ALU_MFLO: ALUOut = w_lo;
            ALU_NOR:  ALUOut = ~(A | B);
            default:  ALUOut = '0;
        endcase
    end

    assign Zero = (ALUOut == '0);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
// ============================================================================
// Module      : tb_multicycle_alu
// Description : Self-checking bench for multicycle_alu (signed cases are
//               compiled when SIGNED_MULDIV_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_alu;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [31:0] A, B;
    logic [3:0]  ALUControl;
    logic        Start;
    logic [31:0] ALUOut;
    logic        Zero, Busy, Done;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    multicycle_alu #(.WIDTH(32)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Start      (Start),
        .ALUOut     (ALUOut),
        .Zero       (Zero),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] comb_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return b << a[4:0];
            ALU_SRL:  return b >> a[4:0];
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_MFHI: return m_hi;
            ALU_MFLO: return m_lo;
            ALU_NOR:  return ~(a | b);
            default:  return 32'd0;
        endcase
    endfunction

    task automatic ref_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            ALU_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            ALU_DIVU: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            ALU_MULT: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            ALU_DIV: begin
                if (b == 0) begin
                    lo = (sa >= 0) ? 32'hFFFF_FFFF : 32'd1;
                    hi = a;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = q;
                    lo = p[31:0];
                    p  = r;
                    hi = p[31:0];
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic comb_step(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        ALUControl = op;
        A = a;
        B = b;
        #1;
        e = comb_ref(op, a, b);
        check(tag, {32'd0, ALUOut}, {32'd0, e});
        check({tag, "_zero"}, {63'd0, Zero}, {63'd0, (e == 32'd0)});
    endtask

    // Launch one mul/div; inj>0 pulses a competing Start in that cycle
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj);
        int nb, nd, done_at;
        logic [31:0] ehi, elo;
        nb = 0; nd = 0; done_at = 0;
        ref_muldiv(op, a, b, ehi, elo);
        A = a; B = b; ALUControl = op; Start = 1'b1;
        tick();
        Start = 1'b0; A = $urandom; B = $urandom; ALUControl = ALU_MFHI;
        for (int c = 1; c <= 40; c++) begin
            if (Busy) nb++;
            if (Done) begin
                nd++;
                if (done_at == 0) done_at = c;
            end
            if (c == 5) check({tag, "_old_hi"}, {32'd0, ALUOut}, {32'd0, m_hi});
            if (c == inj) begin
                Start = 1'b1; ALUControl = ALU_MULTU; A = 32'h1234_5678; B = 32'd3;
            end
            tick();
            if (c == inj) begin
                Start = 1'b0; ALUControl = ALU_MFHI;
            end
        end
        check({tag, "_busy_cycles"}, 64'(nb), 64'd32);
        check({tag, "_done_cycle"}, 64'(done_at), 64'd33);
        check({tag, "_done_pulses"}, 64'(nd), 64'd1);
        m_hi = ehi;
        m_lo = elo;
        ALUControl = ALU_MFHI; #1;
        check({tag, "_hi"}, {32'd0, ALUOut}, {32'd0, ehi});
        ALUControl = ALU_MFLO; #1;
        check({tag, "_lo"}, {32'd0, ALUOut}, {32'd0, elo});
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        RSTn = 1'b0; Start = 1'b0; A = 32'd7; B = 32'd5; ALUControl = ALU_ADD;
        #2;
        check("rst_add_comb", {32'd0, ALUOut}, 64'd12);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        ALUControl = ALU_MFHI; #1;
        check("rst_hi", {32'd0, ALUOut}, 64'd0);
        ALUControl = ALU_MFLO; #1;
        check("rst_lo", {32'd0, ALUOut}, 64'd0);
        #10 RSTn = 1'b1;
        tick();

        comb_step("add", ALU_ADD, 32'd7, 32'd5);
        comb_step("sub", ALU_SUB, 32'd7, 32'd5);
        comb_step("sub_eq", ALU_SUB, 32'd5, 32'd5);
        comb_step("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        comb_step("sll", ALU_SLL, 32'd4, 32'd1);
        comb_step("nor", ALU_NOR, 32'd0, 32'd0);
        comb_step("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        comb_step("srl", ALU_SRL, 32'd31, 32'h8000_0000);
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            comb_step("rand_comb", op, $urandom, $urandom);
        end

        tick();
        run_op("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("divu", ALU_DIVU, 32'd100, 32'd7, 0);
        run_op("divu_zero", ALU_DIVU, 32'd100, 32'd0, 0);
        run_op("busy_start", ALU_MULTU, 32'd1000, 32'd77, 8);
        run_op("done_start", ALU_DIVU, 32'hDEAD_BEEF, 32'd13, 33);

        // Abort a divide part-way through
        A = 32'd500; B = 32'd9; ALUControl = ALU_DIVU; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("abort_busy_before", {63'd0, Busy}, 64'd1);
        RSTn = 1'b0;
        m_hi = '0;
        m_lo = '0;
        ALUControl = ALU_MFHI; #1;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_done", {63'd0, Done}, 64'd0);
        check("abort_hi", {32'd0, ALUOut}, 64'd0);
        ALUControl = ALU_MFLO; #1;
        check("abort_lo", {32'd0, ALUOut}, 64'd0);
        #3 RSTn = 1'b1;
        tick();
        run_op("after_abort", ALU_DIVU, 32'd100, 32'd7, 0);

`ifdef SIGNED_MULDIV_EN
        run_op("mult_neg", ALU_MULT, 32'hFFFF_FFFD, 32'd4, 0);
        run_op("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_neg_zero", ALU_DIV, 32'hFFFF_FFF9, 32'd0, 0);
`endif

        for (int i = 0; i < 4; i++) begin
            op = ($urandom_range(0, 1) == 0) ? ALU_MULTU : ALU_DIVU;
`ifdef SIGNED_MULDIV_EN
            if ($urandom_range(0, 1) == 1) op = (op == ALU_MULTU) ? ALU_MULT : ALU_DIV;
`endif
            ra = $urandom;
            rb = (i == 1) ? 32'($urandom_range(0, 1000)) : $urandom;
            run_op("rand_muldiv", op, ra, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
